// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the AND-then-serialise UART transmitter.
package tt_uart_pkg;

   // Default bit period in clk cycles.
   localparam int DEFAULT_CLKS_PER_BIT = 16;

   // Frame sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   // Even parity bit: XOR of all data bits.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: tick is high on the last cycle of each bit period.
// Reload restarts a full period of CLKS_PER_BIT cycles.
module uart_baud_cnt
   import tt_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic reload,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] RELOAD_VAL = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: reload on a bit boundary, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (reload) begin
         cnt_d = RELOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/tt_and_uart_tx.sv
// Transmits (data_a & data_b) as an 8N1 (or 8E1) UART frame.
// One holding register behind the shift register lets a second byte queue up
// so frames run back to back. tx is driven from a flop; at the tt_um_ top level
// tx maps to uo_out[0] and rst is !rst_n.
module tt_and_uart_tx
   import tt_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY_EN    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_a,
   input  logic [7:0] data_b,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   uart_state_e state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        tx_q, tx_d;
   logic        reload;
   logic        tick;
   logic        capture;
   logic        bypass;
   logic [7:0]  in_byte;

   assign in_byte = data_a & data_b;
   assign capture = valid && !hold_full_q;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .reload (reload),
      .tick   (tick)
   );

   // Frame sequencer: next state, next line level and holding-register update.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_idx_d   = bit_idx_q;
      tx_d        = tx_q;
      reload      = 1'b0;
      bypass      = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (capture) begin
               // Idle line: the new byte goes straight to the shifter.
               bypass  = 1'b1;
               state_d = START;
               shift_d = in_byte;
               tx_d    = 1'b0;
               reload  = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
               tx_d      = shift_q[0];
               reload    = 1'b1;
            end
         end
         DATA: begin
            if (tick) begin
               reload    = 1'b1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  if (PARITY_EN != 0) begin
                     state_d = PARITY;
                     tx_d    = even_parity(shift_q);
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  tx_d = shift_q[bit_idx_d];
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               tx_d    = 1'b1;
               reload  = 1'b1;
            end
         end
         STOP: begin
            if (tick) begin
               if (hold_full_q) begin
                  // Queued byte starts with no idle gap.
                  state_d     = START;
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
                  tx_d        = 1'b0;
                  reload      = 1'b1;
               end else if (capture) begin
                  // Byte arriving on the last stop cycle also starts at once.
                  bypass  = 1'b1;
                  state_d = START;
                  shift_d = in_byte;
                  tx_d    = 1'b0;
                  reload  = 1'b1;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // A byte accepted mid-frame waits in the holding register.
      if (capture && !bypass) begin
         hold_d      = in_byte;
         hold_full_d = 1'b1;
      end
   end

   // State and datapath registers; reset aborts any frame and drops the held byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_idx_q   <= '0;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_idx_q   <= bit_idx_d;
         tx_q        <= tx_d;
      end
   end

   assign ready = !hold_full_q;
   assign busy  = (state_q != IDLE) || hold_full_q;
   assign tx    = tx_q;

endmodule

// File: tb/tb_tt_and_uart_tx.sv
// Testbench for tt_and_uart_tx: the expected line is built from frames of
// accepted bytes queued back to back, one entry per clk cycle.
module tb_tt_and_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data_a = 8'h00;
   logic [7:0] data_b = 8'h00;
   logic       ready0, tx0, busy0;
   logic       ready1, tx1, busy1;

   int n_assert = 0;
   int n_fail   = 0;
   bit sel      = 1'b0;   // 0: checks the no-parity DUT, 1: the parity DUT
   bit last_cap = 1'b0;
   bit exp_q[$];

   tt_and_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
      .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b),
      .valid(valid), .ready(ready0), .tx(tx0), .busy(busy0)
   );

   tt_and_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
      .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b),
      .valid(valid), .ready(ready1), .tx(tx1), .busy(busy1)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   function automatic void push_bit(input bit v);
      for (int i = 0; i < CPB; i++) exp_q.push_back(v);
   endfunction

   // One UART frame: start, 8 data bits LSB first, optional even parity, stop.
   function automatic void push_frame(input logic [7:0] b, input bit par);
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(b[i]);
      if (par) push_bit(^b);
      push_bit(1'b1);
   endfunction

   // One clock cycle: compare line/ready/busy with the model, then advance.
   // The model is ready unless a complete second frame is already queued.
   task automatic cyc();
      int         fl;
      bit         e;
      bit         ready_e;
      bit         busy_e;
      bit         cap;
      logic [7:0] b;
      fl      = sel ? 11 * CPB : 10 * CPB;
      ready_e = (exp_q.size() <= fl);
      busy_e  = (exp_q.size() > 0);
      e       = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      chk("tx",    sel ? tx1 : tx0, e);
      chk("ready", sel ? ready1 : ready0, ready_e);
      chk("busy",  sel ? busy1 : busy0, busy_e);
      cap = valid && ready_e;
      b   = data_a & data_b;
      @(posedge clk);
      #1;
      last_cap = cap;
      if (cap) push_frame(b, sel);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx",    sel ? tx1 : tx0, 1'b1);
      chk("reset_ready", sel ? ready1 : ready0, 1'b1);
      chk("reset_busy",  sel ? busy1 : busy0, 1'b0);
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Offer one operand pair and hold valid until the model accepts it.
   task automatic offer(input logic [7:0] a, input logic [7:0] b);
      int waited;
      data_a = a;
      data_b = b;
      valid  = 1'b1;
      waited = 0;
      do begin
         cyc();
         waited++;
      end while (!last_cap && waited < 200);
      if (!last_cap) chk("handshake_timeout", 1'b0, 1'b1);
      valid = 1'b0;
   endtask

   initial begin
      #1;
      // Basic frame, no parity: 0xFF & 0xA5.
      sel = 1'b0;
      do_reset();
      offer(8'hFF, 8'hA5);
      idle(45);

      // Same byte with even parity: 44-cycle frame.
      sel = 1'b1;
      do_reset();
      offer(8'hFF, 8'hA5);
      idle(50);

      // AND of the operands: 0x5A & 0x0F = 0x0A.
      sel = 1'b0;
      do_reset();
      offer(8'h5A, 8'h0F);
      idle(45);

      // Three back-to-back bytes; the third waits for the holding register.
      do_reset();
      offer(8'h0F, 8'hFF);
      offer(8'hF0, 8'hFF);
      offer(8'h3C, 8'hFF);
      idle(130);

      // Capture on the very last stop cycle of a frame.
      do_reset();
      offer(8'hC3, 8'hFF);
      idle(10 * CPB - 1);
      offer(8'h96, 8'hFF);
      idle(90);

      // Reset during data bit 3 with a byte held; valid high during reset.
      do_reset();
      offer(8'hB4, 8'hFF);
      offer(8'h11, 8'hFF);
      idle(4 * CPB);
      rst    = 1'b1;
      valid  = 1'b1;
      data_a = 8'hFF;
      data_b = 8'hFF;
      @(posedge clk);
      #1;
      chk("midreset_tx",    tx0, 1'b1);
      chk("midreset_busy",  busy0, 1'b0);
      chk("midreset_ready", ready0, 1'b1);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      valid = 1'b0;
      exp_q.delete();
      idle(60);

      // Randomised bytes and gaps against the model, both parity settings.
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         do_reset();
         for (int k = 0; k < 8; k++) begin
            idle($urandom_range(0, 50));
            offer(8'($urandom), 8'($urandom));
         end
         idle(100);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
